// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner: scan states and hex glyphs
// for the optional 7-segment display.
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } scan_state_t;

    // Active-low glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: a raw value differing from the accepted state must persist
// for DEBOUNCE_SCANS consecutive frame ends before it is accepted.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic frame_end,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (frame_end) begin
            if (raw == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                deb <= raw;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row/column keypad scanner with frame-based debounce and one-event-per-cycle reporting.
// Define KEYPAD_SEG7_EN to add seg_n showing the hex code of the most recent press.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_SCANS  = 2,
    parameter int ROW_ACTIVE_HIGH = 1,
    parameter int COL_ACTIVE_HIGH = 1,
    localparam int NK = ROWS * COLS,
    localparam int KW = (NK > 1) ? $clog2(NK) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic            key_event,
    output logic            key_pressed,
    output logic [KW-1:0]   key_code,
    output logic [NK-1:0]   key_bitmap,
    output logic            any_key
`ifdef KEYPAD_SEG7_EN
    ,
    output logic [6:0]      seg_n
`endif
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES);

    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("keypad_matrix_scanner: SETTLE_CYCLES must be at least 2");
    end

    scan_state_t     state, state_nxt;
    logic [RW-1:0]   row_idx, row_nxt;
    logic [SW-1:0]   settle_cnt, settle_nxt;
    logic [ROWS-1:0] row_sel, row_drive;
    logic [COLS-1:0] col_sync_p0, col_sync_p1, col_norm;
    logic [NK-1:0]   raw, raw_nxt, deb, pending, bitmap_nxt;
    logic            frame_end, pend_any;
    logic [KW-1:0]   pend_idx;

    // Stage p0/p1: two-flop synchroniser on the asynchronous column pins
    always_ff @(posedge CLK) begin
        if (RST) begin
            col_sync_p0 <= '0;
            col_sync_p1 <= '0;
        end else begin
            col_sync_p0 <= col_in;
            col_sync_p1 <= col_sync_p0;
        end
    end

    assign col_norm = (COL_ACTIVE_HIGH != 0) ? col_sync_p1 : ~col_sync_p1;

    // Scan FSM: row_out is registered from the next row index so it lines up with DRIVE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= DRIVE;
            row_idx    <= '0;
            settle_cnt <= '0;
            row_out    <= (ROW_ACTIVE_HIGH != 0) ? {ROWS{1'b0}} : {ROWS{1'b1}};
        end else begin
            state      <= state_nxt;
            row_idx    <= row_nxt;
            settle_cnt <= settle_nxt;
            row_out    <= row_drive;
        end
    end

    always_comb begin
        state_nxt  = state;
        row_nxt    = row_idx;
        settle_nxt = settle_cnt;
        case (state)
            DRIVE: begin
                state_nxt  = SETTLE;
                settle_nxt = '0;
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
                else settle_nxt = settle_cnt + 1'b1;
            end
            SAMPLE: begin
                state_nxt = DRIVE;
                row_nxt   = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
            end
            default: state_nxt = DRIVE;
        endcase
    end

    assign row_sel   = ROWS'(1) << row_nxt;
    assign row_drive = (ROW_ACTIVE_HIGH != 0) ? row_sel : ~row_sel;

    // The debouncers see the frame including the row being sampled right now
    always_comb begin
        raw_nxt = raw;
        if (state == SAMPLE) raw_nxt[row_idx*COLS +: COLS] = col_norm;
    end

    assign frame_end = (state == SAMPLE) && (row_idx == RW'(ROWS - 1));

    always_ff @(posedge CLK) begin
        if (RST) raw <= '0;
        else     raw <= raw_nxt;
    end

    for (genvar k = 0; k < NK; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_deb (
            .CLK       (CLK),
            .RST       (RST),
            .frame_end (frame_end),
            .raw       (raw_nxt[k]),
            .deb       (deb[k])
        );
    end

    // Reporting: drain accepted-but-unreported changes, lowest key code first
    assign pending = deb ^ key_bitmap;

    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pend_any = 1'b1;
                pend_idx = KW'(i);
            end
        end
    end

    assign bitmap_nxt = key_bitmap ^ (NK'(pend_any) << pend_idx);

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_event   <= 1'b0;
            key_pressed <= 1'b0;
            key_code    <= '0;
            key_bitmap  <= '0;
            any_key     <= 1'b0;
        end else begin
            key_event  <= pend_any;
            key_bitmap <= bitmap_nxt;
            any_key    <= |bitmap_nxt;
            if (pend_any) begin
                key_code    <= pend_idx;
                key_pressed <= deb[pend_idx];
            end
        end
    end

`ifdef KEYPAD_SEG7_EN
    always_ff @(posedge CLK) begin
        if (RST)                            seg_n <= SEG_BLANK;
        else if (key_event && key_pressed)  seg_n <= SEG_HEX[4'(key_code)];
    end
`endif

endmodule
